fir_mac_ctrl: RTL
=================

Name: fir_mac_ctrl

Overview:
Sequencer for the 4-tap FIR MAC datapath. Holds the 4 coefficient registers and the 4-deep sample delay line that feed the MAC. Accepts one input sample per valid/ready handshake, shifts it into the delay line, and runs the MAC enable/done handshake. Captures the 10-bit accumulation and presents it on a valid/ready output port. Sits between the sample source and the MAC instance in the FIR top level.

Parameters:
DATA_W, 8, sample/coefficient width (signed Q1.7)
ACC_W, 10, MAC result width
TIMEOUT_CYCLES, 64, max RUN cycles without mac_done (used only with FIR_MAC_CTRL_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  input sample valid
in_ready  out  1  controller can accept sample
in_data  in  DATA_W  input sample x[n]
flush  in  1  zero the delay line (honoured in IDLE only)
coef_wr  in  1  coefficient write strobe
coef_addr  in  2  coefficient index 0..3
coef_wdata  in  DATA_W  coefficient value
mac_enable  out  1  to MAC; held high for the whole computation
mac_done  in  1  from MAC; result valid
mac_data_out  in  ACC_W  MAC accumulation result
h_0..h_3  out  DATA_W each  coefficient registers to MAC
data_0..data_3  out  DATA_W each  delay line to MAC; data_0 = newest
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  ACC_W  registered result
busy  out  1  state != IDLE
timeout_err  out  1  one-cycle pulse (feature only; tied 0 otherwise)

Behaviour:
- Reset (async, rst=1): state IDLE; h_*, data_*, out_data = 0; mac_enable, out_valid, timeout_err = 0; in_ready = 1.
- States: IDLE, RUN, OUT. All outputs registered, except in_ready = (state==IDLE) and busy.
- IDLE: on in_valid&in_ready at edge E0:
  - shift data_3<=data_2, data_2<=data_1, data_1<=data_0, data_0<=in_data.
  - mac_enable<=1, state->RUN. mac_enable is first high in the cycle after E0.
- IDLE with flush=1 and no handshake: all data_* <= 0. With flush and handshake in the same cycle, flush wins: delay line zeroed, sample dropped, no RUN.
- Coefficient writes: accepted only in IDLE; h_[coef_addr] <= coef_wdata. Writes in RUN/OUT are ignored, so coefficients stay stable during a computation.
- RUN: mac_enable held at 1. On the edge where mac_done=1:
  - out_data <= mac_data_out; out_valid <= 1; mac_enable <= 0; state->OUT.
  - data_*/h_* unchanged throughout RUN.
- OUT: out_valid held and out_data stable until out_ready=1. At that edge out_valid<=0 and state->IDLE. in_ready rises one cycle after the accepting edge.
- mac_done outside RUN is ignored.
- Minimum period per sample: 1 (accept) + MAC latency + 1 (output) cycles. No overlap between samples.
- Reset mid-RUN/OUT: immediate return to reset values; the pending result is lost.

Optional Feature:
Macro FIR_MAC_CTRL_TIMEOUT_EN.
- Defined: an 8-bit-min counter clears on RUN entry and increments each RUN cycle. If it reaches TIMEOUT_CYCLES without mac_done: mac_enable<=0, timeout_err pulses 1 cycle, state->IDLE, no output. The delay line keeps the shifted sample.
- Undefined: no counter; RUN waits indefinitely; timeout_err tied 0.

Decomposition:
- Package fir_pkg: DATA_W, ACC_W, NTAPS=4, state encoding constants (IDLE=2'd0, RUN=2'd1, OUT=2'd2).
- One sub-module, fir_tap_line: delay line plus coefficient register file with shift/flush/write controls.
- FSM and handshakes stay in fir_mac_ctrl.

Test Plan:
- Bench MAC model: 3-cycle mac_done latency, returns a fixed value.
- Reset then write h=0x40,0x40,0x40,0xC0 in IDLE; push 0x20 -> h_0..h_3 = 40/40/40/C0; data_0=0x20, others 0; mac_enable high for 3 cycles; out_data=model value 0x155; out_valid high.
- Push 0x20,0x40,0x40,0xC0 sequentially, out_ready=1 -> after 4th sample data_0..3 = C0,40,40,20; 4 results delivered; in_ready low during each RUN/OUT.
- out_ready=0 for 5 cycles in OUT -> out_valid and out_data stable; in_ready=0; no second sample accepted; releases 1 cycle after out_ready.
- coef_wr addr 2 data 0x7F during RUN -> h_2 unchanged. Flush with in_valid in IDLE -> data_* = 0, no mac_enable.
- Assert rst while in RUN -> mac_enable, out_valid, data_*, h_* = 0 immediately (async).
- With FIR_MAC_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=8, model never asserts mac_done -> after 8 RUN cycles timeout_err pulses once, IDLE, in_ready=1, out_valid stays 0.

Source files
------------

// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared constants for the 4-tap FIR MAC sequencer:
//   DATA_W  - sample/coefficient width (signed Q1.7)
//   ACC_W   - MAC accumulation width
//   NTAPS   - number of taps / delay-line depth
//   ST_*    - sequencer state encoding (IDLE, RUN, OUT)
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 10;
    localparam int NTAPS  = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

endpackage

// File: rtl/fir_tap_line.sv
// ---------------------------------------------------------------------------
// fir_tap_line
// Sample delay line plus coefficient register file feeding the MAC.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (clears all taps)
//   shift_i    - push sample_i into tap 0, older samples move up one tap
//   flush_i    - zero the whole delay line (has priority over shift_i)
//   sample_i   - new sample x[n]
//   wr_i       - coefficient write strobe
//   waddr_i    - coefficient index 0..3
//   wdata_i    - coefficient value
//   data_o     - delay line, index 0 = newest sample
//   coef_o     - coefficient registers h[0..3]
// Gating of shift/flush/write by the sequencer state is done by the caller.
// ---------------------------------------------------------------------------
module fir_tap_line
    import fir_pkg::*;
#(
    parameter int DATA_W = fir_pkg::DATA_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           shift_i,
    input  logic                           flush_i,
    input  logic [DATA_W-1:0]              sample_i,
    input  logic                           wr_i,
    input  logic [1:0]                     waddr_i,
    input  logic [DATA_W-1:0]              wdata_i,
    output logic [NTAPS-1:0][DATA_W-1:0]   data_o,
    output logic [NTAPS-1:0][DATA_W-1:0]   coef_o
);

    logic [NTAPS-1:0][DATA_W-1:0] data_q, data_d;
    logic [NTAPS-1:0][DATA_W-1:0] coef_q, coef_d;

    always_comb begin
        data_d = data_q;
        coef_d = coef_q;
        if (flush_i) begin
            data_d = '0;
        end else if (shift_i) begin
            // Packed concat: the new sample lands in element 0, element k moves to k+1.
            data_d = {data_q[NTAPS-2:0], sample_i};
        end
        if (wr_i) begin
            coef_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            coef_q <= '0;
        end else begin
            data_q <= data_d;
            coef_q <= coef_d;
        end
    end

    assign data_o = data_q;
    assign coef_o = coef_q;

endmodule

// File: rtl/fir_mac_ctrl.sv
// ---------------------------------------------------------------------------
// fir_mac_ctrl
// Sequencer for the 4-tap FIR MAC datapath. Accepts one sample per
// in_valid/in_ready handshake, shifts it into the delay line, holds
// mac_enable until mac_done, captures the result and offers it on an
// out_valid/out_ready port. One sample in flight at a time.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   in_valid/in_ready/in_data - sample input handshake (in_ready = IDLE)
//   flush                    - zero the delay line (IDLE only, beats in_valid)
//   coef_wr/coef_addr/coef_wdata - coefficient write (IDLE only)
//   mac_enable/mac_done/mac_data_out - MAC handshake and result
//   h_0..h_3                 - coefficient registers to the MAC
//   data_0..data_3           - delay line to the MAC, data_0 = newest
//   out_valid/out_ready/out_data - registered result handshake
//   busy                     - state != IDLE
//   timeout_err              - one-cycle pulse on RUN timeout
// Optional feature: define FIR_MAC_CTRL_TIMEOUT_EN to abort RUN after
// TIMEOUT_CYCLES cycles without mac_done (otherwise RUN waits forever and
// timeout_err is tied low).
// ---------------------------------------------------------------------------
module fir_mac_ctrl
    import fir_pkg::*;
#(
    parameter int DATA_W         = fir_pkg::DATA_W,
    parameter int ACC_W          = fir_pkg::ACC_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    input  logic              coef_wr,
    input  logic [1:0]        coef_addr,
    input  logic [DATA_W-1:0] coef_wdata,
    output logic              mac_enable,
    input  logic              mac_done,
    input  logic [ACC_W-1:0]  mac_data_out,
    output logic [DATA_W-1:0] h_0,
    output logic [DATA_W-1:0] h_1,
    output logic [DATA_W-1:0] h_2,
    output logic [DATA_W-1:0] h_3,
    output logic [DATA_W-1:0] data_0,
    output logic [DATA_W-1:0] data_1,
    output logic [DATA_W-1:0] data_2,
    output logic [DATA_W-1:0] data_3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              busy,
    output logic              timeout_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fir_mac_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]       state_q, state_d;
    logic             mac_en_q, mac_en_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;

    logic is_idle, accept, flush_en, coef_we;
    logic [NTAPS-1:0][DATA_W-1:0] taps, coefs;

    assign is_idle  = (state_q == ST_IDLE);
    // Flush beats a simultaneous handshake: the sample is dropped.
    assign accept   = is_idle && in_valid && !flush;
    assign flush_en = is_idle && flush;
    // Coefficients only change between computations.
    assign coef_we  = is_idle && coef_wr;

`ifdef FIR_MAC_CTRL_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic             to_err_q, to_err_d;

    // Counter is held at zero outside RUN, so it starts from zero on RUN entry.
    assign to_cnt_d = (state_q == ST_RUN) ? to_cnt_q + 1'b1 : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_err_q <= to_err_d;
        end
    end

    assign timeout_err = to_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mac_en_d    = mac_en_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
`ifdef FIR_MAC_CTRL_TIMEOUT_EN
        to_err_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mac_en_d = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mac_done) begin
                    out_data_d  = mac_data_out;
                    out_valid_d = 1'b1;
                    mac_en_d    = 1'b0;
                    state_d     = ST_OUT;
                end
`ifdef FIR_MAC_CTRL_TIMEOUT_EN
                // to_cnt_q == TO_LAST means this is the TIMEOUT_CYCLES-th RUN cycle.
                else if (to_cnt_q == TO_LAST) begin
                    mac_en_d = 1'b0;
                    to_err_d = 1'b1;
                    state_d  = ST_IDLE;
                end
`endif
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                mac_en_d    = 1'b0;
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mac_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mac_en_q    <= mac_en_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    fir_tap_line #(
        .DATA_W (DATA_W)
    ) u_tap_line (
        .clk      (clk),
        .rst      (rst),
        .shift_i  (accept),
        .flush_i  (flush_en),
        .sample_i (in_data),
        .wr_i     (coef_we),
        .waddr_i  (coef_addr),
        .wdata_i  (coef_wdata),
        .data_o   (taps),
        .coef_o   (coefs)
    );

    assign in_ready   = is_idle;
    assign busy       = !is_idle;
    assign mac_enable = mac_en_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;

    assign h_0 = coefs[0];
    assign h_1 = coefs[1];
    assign h_2 = coefs[2];
    assign h_3 = coefs[3];

    assign data_0 = taps[0];
    assign data_1 = taps[1];
    assign data_2 = taps[2];
    assign data_3 = taps[3];

endmodule
